// File: rtl/instr_fetch_reg.sv
// Instruction fetch sequencer + 32-bit instruction register feeding the byte reducer.
// Latency: start -> mem_req next cycle; mem_ack -> ir_valid/ir_out next cycle (1 word / 2 cycles peak).
// Backpressure: ir_ready=0 holds ir_valid/ir_out indefinitely and no new fetch is issued.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_start, i_halt           begin fetching / clear error; stop after current word is consumed
//   o_mem_req, o_mem_addr     instruction memory read request and address (address = pc)
//   i_mem_ack, i_mem_rdata    memory read data valid and data
//   o_ir_out, o_ir_valid      instruction register and its valid flag
//   i_ir_ready                downstream accepts o_ir_out this cycle
//   o_pc_out                  address of the next word to fetch
//   o_busy                    fetching or holding an instruction
//   o_err_timeout             sticky memory-ack timeout flag, cleared by i_start
module instr_fetch_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_halt,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata,
    output logic [31:0]       o_ir_out,
    output logic              o_ir_valid,
    input  logic              i_ir_ready,
    output logic [ADDR_W-1:0] o_pc_out,
    output logic              o_busy,
    output logic              o_err_timeout
);

    // Counter only needs to reach TIMEOUT-1; the final unacked cycle trips the error.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       r_ir;
    logic [31:0]       w_ir_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_err;
    logic              w_err_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                // halt has no meaning until a fetch is in flight
                if (i_start) begin
                    w_state_nxt = S_REQ;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (i_mem_ack) begin
                    w_ir_nxt    = i_mem_rdata;
                    w_pc_nxt    = r_pc + ADDR_W'(4);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (i_ir_ready) begin
                    w_state_nxt = i_halt ? S_IDLE : S_REQ;
                end
            end
            S_ERR: begin
                // Retry from the same pc; it was never advanced on timeout.
                if (i_start) begin
                    w_err_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_mem_req     = (r_state == S_REQ);
    assign o_mem_addr    = r_pc;
    assign o_ir_out      = r_ir;
    assign o_ir_valid    = (r_state == S_HOLD);
    assign o_pc_out      = r_pc;
    assign o_busy        = (r_state == S_REQ) || (r_state == S_HOLD);
    assign o_err_timeout = r_err;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Self-checking bench for instr_fetch_reg: directed scenarios, then randomized traffic
// checked by a transaction scoreboard (expected fetch addresses and delivered words).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_instr_fetch_reg;

    localparam int TIMEOUT = 15;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_halt;
    logic        o_mem_req;
    logic [15:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_ir_out;
    logic        o_ir_valid;
    logic        i_ir_ready;
    logic [15:0] o_pc_out;
    logic        o_busy;
    logic        o_err_timeout;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_reg #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_start       (i_start),
        .i_halt        (i_halt),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_ir_out      (o_ir_out),
        .o_ir_valid    (o_ir_valid),
        .i_ir_ready    (i_ir_ready),
        .o_pc_out      (o_pc_out),
        .o_busy        (o_busy),
        .o_err_timeout (o_err_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] sb[$];
    logic [31:0] words[8];
    logic [31:0] exp_word;
    logic [15:0] exp_pc;
    int          miss;
    int          ack_pct;
    logic        found;
    logic        p_req, p_vld, p_err, p_busy;
    logic [31:0] p_ir;
    logic [15:0] p_addr;

    initial begin
        i_rst_n     = 1'b0;
        i_start     = 1'b0;
        i_halt      = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        i_ir_ready  = 1'b0;
        #1;
        chk("rst_req",   32'(o_mem_req),     32'd0);
        chk("rst_valid", 32'(o_ir_valid),    32'd0);
        chk("rst_err",   32'(o_err_timeout), 32'd0);
        chk("rst_pc",    32'(o_pc_out),      32'h0);
        chk("rst_ir",    o_ir_out,           32'h0);
        repeat (3) step();
        i_rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Basic fetch
        i_start = 1'b1; step(); i_start = 1'b0;
        chk("f_req",  32'(o_mem_req),  32'd1);
        chk("f_addr", 32'(o_mem_addr), 32'h0);
        chk("f_busy", 32'(o_busy),     32'd1);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hDEADBEEF; step(); i_mem_ack = 1'b0;
        chk("f_valid", 32'(o_ir_valid), 32'd1);
        chk("f_ir",    o_ir_out,        32'hDEADBEEF);
        chk("f_pc",    32'(o_pc_out),   32'h4);

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(o_ir_valid), 32'd1);
            chk("bp_ir",    o_ir_out,        32'hDEADBEEF);
            chk("bp_req",   32'(o_mem_req),  32'd0);
        end
        i_ir_ready = 1'b1; step(); i_ir_ready = 1'b0;
        chk("bp_rel_req",  32'(o_mem_req),  32'd1);
        chk("bp_rel_addr", 32'(o_mem_addr), 32'h4);

        // Halt with the handshake, then a stray ack in IDLE
        i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFEF00D; step(); i_mem_ack = 1'b0;
        chk("h_ir", o_ir_out, 32'hCAFEF00D);
        i_ir_ready = 1'b1; i_halt = 1'b1; step(); i_ir_ready = 1'b0; i_halt = 1'b0;
        chk("h_busy",  32'(o_busy),     32'd0);
        chk("h_valid", 32'(o_ir_valid), 32'd0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h12345678; step(); i_mem_ack = 1'b0;
        chk("stray_ir",  o_ir_out,      32'hCAFEF00D);
        chk("stray_pc",  32'(o_pc_out), 32'h8);
        chk("stray_req", 32'(o_mem_req), 32'd0);

        // Reset in the middle of a request
        i_start = 1'b1; step(); i_start = 1'b0;
        chk("mr_req_before", 32'(o_mem_req), 32'd1);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mr_req",   32'(o_mem_req),     32'd0);
        chk("mr_valid", 32'(o_ir_valid),    32'd0);
        chk("mr_err",   32'(o_err_timeout), 32'd0);
        chk("mr_pc",    32'(o_pc_out),      32'h0);
        chk("mr_ir",    o_ir_out,           32'h0);
        step();
        i_rst_n = 1'b1;
        step();
        chk("mr_idle", 32'(o_busy), 32'd0);

        // Timeout after 15 unacked REQ cycles, then retry; ack on the 15th cycle wins
        i_start = 1'b1; step(); i_start = 1'b0;
        repeat (TIMEOUT - 1) step();
        chk("to_err_early", 32'(o_err_timeout), 32'd0);
        chk("to_req_early", 32'(o_mem_req),     32'd1);
        step();
        chk("to_err",  32'(o_err_timeout), 32'd1);
        chk("to_req",  32'(o_mem_req),     32'd0);
        chk("to_pc",   32'(o_pc_out),      32'h0);
        chk("to_busy", 32'(o_busy),        32'd0);
        step();
        chk("to_sticky", 32'(o_err_timeout), 32'd1);
        i_start = 1'b1; step(); i_start = 1'b0;
        chk("retry_err",  32'(o_err_timeout), 32'd0);
        chk("retry_req",  32'(o_mem_req),     32'd1);
        chk("retry_addr", 32'(o_mem_addr),    32'h0);
        repeat (TIMEOUT - 1) step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0BADF00D; step(); i_mem_ack = 1'b0;
        chk("lastack_err",   32'(o_err_timeout), 32'd0);
        chk("lastack_valid", 32'(o_ir_valid),    32'd1);
        chk("lastack_ir",    o_ir_out,           32'h0BADF00D);
        chk("lastack_pc",    32'(o_pc_out),      32'h4);
        i_ir_ready = 1'b1; i_halt = 1'b1; step(); i_ir_ready = 1'b0; i_halt = 1'b0;

        // Stream up to the top of the address space, then check wrap and cadence
        i_start = 1'b1; step(); i_start = 1'b0;
        i_ir_ready = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
        found = 1'b0;
        for (int k = 0; k < 40000 && !found; k++) begin
            if (o_mem_req && o_pc_out == 16'hFFFC) found = 1'b1;
            else step();
        end
        chk("reach_fffc", 32'(found), 32'd1);
        i_mem_rdata = 32'hA5A50001; step();
        chk("wrap_pc", 32'(o_pc_out), 32'h0);
        chk("wrap_ir", o_ir_out,      32'hA5A50001);
        for (int i = 0; i < 8; i++) words[i] = $urandom;
        for (int c = 1; c <= 16; c++) begin
            i_mem_rdata = words[(c - 1) >> 1];
            step();
            if (c % 2 == 1) begin
                chk("strm_gap",  32'(o_ir_valid), 32'd0);
                chk("strm_addr", 32'(o_mem_addr), 32'((c - 1) / 2 * 4));
            end else begin
                chk("strm_valid", 32'(o_ir_valid), 32'd1);
                chk("strm_word",  o_ir_out,        words[c / 2 - 1]);
            end
        end
        i_mem_ack = 1'b0; i_halt = 1'b1; step(); i_halt = 1'b0; i_ir_ready = 1'b0;
        chk("strm_end_busy", 32'(o_busy),   32'd0);
        chk("strm_end_pc",   32'(o_pc_out), 32'(8 * 4));

        // Randomized traffic against the scoreboard
        exp_pc = 16'(8 * 4);
        miss   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ack_pct     = ((cyc / 64) % 5 == 3) ? 0 : 75;
            i_mem_ack   = ($urandom_range(99) < ack_pct);
            i_mem_rdata = $urandom;
            i_ir_ready  = ($urandom_range(99) < 60);
            i_halt      = ($urandom_range(99) < 15);
            i_start     = ($urandom_range(99) < 20);
            p_req  = o_mem_req;
            p_vld  = o_ir_valid;
            p_err  = o_err_timeout;
            p_busy = o_busy;
            p_ir   = o_ir_out;
            p_addr = o_mem_addr;
            step();
            if (p_req) begin
                chk("r_addr", 32'(p_addr), 32'(exp_pc));
                if (i_mem_ack) begin
                    sb.push_back(i_mem_rdata);
                    exp_pc = exp_pc + 16'd4;
                    miss   = 0;
                    chk("r_cap_valid", 32'(o_ir_valid), 32'd1);
                    chk("r_cap_ir",    o_ir_out,        i_mem_rdata);
                end else begin
                    miss++;
                    if (miss == TIMEOUT) begin
                        chk("r_to_err", 32'(o_err_timeout), 32'd1);
                        chk("r_to_req", 32'(o_mem_req),     32'd0);
                        miss = 0;
                    end else begin
                        chk("r_wait_req", 32'(o_mem_req),     32'd1);
                        chk("r_wait_err", 32'(o_err_timeout), 32'd0);
                    end
                end
                chk("r_pc", 32'(o_pc_out), 32'(exp_pc));
            end else begin
                chk("r_ir_stable", o_ir_out, p_ir);
            end
            if (p_vld) begin
                if (i_ir_ready) begin
                    chk("r_sb_depth", 32'(sb.size()), 32'd1);
                    exp_word = (sb.size() > 0) ? sb.pop_front() : 32'h0;
                    chk("r_deliver",     p_ir,            exp_word);
                    chk("r_after_hs",    32'(o_ir_valid), 32'd0);
                    chk("r_hs_next_req", 32'(o_mem_req),  32'(!i_halt));
                end else begin
                    chk("r_stall_valid", 32'(o_ir_valid), 32'd1);
                end
            end
            if (p_err) begin
                if (i_start) begin
                    chk("r_retry_req", 32'(o_mem_req),     32'd1);
                    chk("r_retry_err", 32'(o_err_timeout), 32'd0);
                    miss = 0;
                end else begin
                    chk("r_err_sticky", 32'(o_err_timeout), 32'd1);
                end
            end else if (!p_busy) begin
                chk("r_idle_start", 32'(o_mem_req), 32'(i_start));
            end
            chk("r_busy_decode", 32'(o_busy), 32'(o_mem_req || o_ir_valid));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
